// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the word-array RAM.
// The default geometry matches a 3-to-8 address decoder driving eight 8-bit words.
package ram_pkg;

    localparam int DEFAULT_WORDS = 8;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Clear-counter width, kept at least 1 bit so a single-word array still has a counter.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot test: o_valid is 1 only when exactly one bit of i_vec is set.
// Clearing the lowest set bit leaves zero only for a power of two.
module onehot_check #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_vec,
    output logic         o_valid
);

    logic [N-1:0] w_low_cleared;

    assign w_low_cleared = i_vec & (i_vec - N'(1));
    assign o_valid       = (i_vec != '0) && (w_low_cleared == '0);

endmodule

// File: rtl/ram_word_array.sv
// Register-file style RAM addressed by one-hot word selects, with a single-cycle
// access handshake and a sequential whole-array clear that walks one word per cycle.
module ram_word_array
    import ram_pkg::*;
#(
    parameter int WORDS = DEFAULT_WORDS,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [WORDS-1:0] sel,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic             ready,
    output logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             err
);

    localparam int CNT_W = cnt_width(WORDS);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_clr_cnt;
    logic [WIDTH-1:0] r_mem [WORDS];
    logic             r_ack;
    logic             r_err;
    logic [WIDTH-1:0] r_dout;

    logic             w_sel_valid;
    logic             w_accept;
    logic             w_wr_en;
    logic             w_clearing;
    logic             w_clr_last;
    logic [WIDTH-1:0] w_rd_data;

    onehot_check #(
        .N(WORDS)
    ) u_onehot_check (
        .i_vec  (sel),
        .o_valid(w_sel_valid)
    );

    assign ready      = (r_state == ST_IDLE);
    // A clear request wins over an access arriving in the same cycle.
    assign w_accept   = req && ready && !clr;
    assign w_wr_en    = w_accept && we && w_sel_valid;
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_clr_last = (r_clr_cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: assign every always_comb output a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (clr)        w_next_state = ST_CLEAR;
            ST_CLEAR: if (w_clr_last) w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // The counter leaves CLEAR on the same edge that zeroes the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (w_clearing) begin
            r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + CNT_W'(1);
        end
    end

    // NOTE: the array is flops, not a RAM macro, so it can and must be cleared by reset.
    for (genvar g = 0; g < WORDS; g++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[g] <= '0;
            end else if (w_clearing && (r_clr_cnt == CNT_W'(g))) begin
                r_mem[g] <= '0;
            end else if (w_wr_en && sel[g]) begin
                r_mem[g] <= din;
            end
        end
    end

    // AND-OR mux; only meaningful when sel is one-hot, which is the only case it is used.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (sel[i]) w_rd_data = w_rd_data | r_mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_ack <= w_accept;
            r_err <= w_accept && !w_sel_valid;
            if (w_accept) begin
                if (!w_sel_valid) begin
                    r_dout <= '0;
                end else if (!we) begin
                    r_dout <= w_rd_data;
                end
            end
        end
    end

    assign ack  = r_ack;
    assign err  = r_err;
    assign dout = r_dout;

endmodule

// File: tb/tb_ram_word_array.sv
// Directed bench for ram_word_array: a table of single-cycle accesses with
// hand-computed responses, then clear and reset-during-clear sequences.
module tb_ram_word_array;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       we;
    logic [7:0] sel;
    logic [7:0] din;
    logic       clr;
    logic       ready;
    logic       ack;
    logic [7:0] dout;
    logic       err;

    int total = 0;
    int bad   = 0;

    ram_word_array #(
        .WORDS(8),
        .WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .we   (we),
        .sel  (sel),
        .din  (din),
        .clr  (clr),
        .ready(ready),
        .ack  (ack),
        .dout (dout),
        .err  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       req;
        logic       we;
        logic [7:0] sel;
        logic [7:0] din;
        logic       exp_ack;
        logic       exp_err;
        logic [7:0] exp_dout;
        logic       chk_dout;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, cross the rising edge, then settle 1 time unit.
    task automatic cycle(input logic r, input logic w, input logic [7:0] s,
                         input logic [7:0] d, input logic c);
        req = r;
        we  = w;
        sel = s;
        din = d;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] s;
            s = 8'(1 << i);
            cycle(1'b1, 1'b0, s, 8'h00, 1'b0);
            check({tag, "_ack"}, 32'(ack), 32'd1);
            check({tag, "_dout"}, 32'(dout), 32'h00);
        end
    endtask

    task automatic fill_ff();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] s;
            s = 8'(1 << i);
            cycle(1'b1, 1'b1, s, 8'hFF, 1'b0);
        end
    endtask

    initial begin
        int low_cnt;

        vecs[0]  = '{"wr_a5_w2",    1'b1, 1'b1, 8'h04, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{"rd_w2",       1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[2]  = '{"wr_3c_w7",    1'b1, 1'b1, 8'h80, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[3]  = '{"rd_w7_b2b",   1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[4]  = '{"no_req",      1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{"rd_sel_zero", 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
        vecs[6]  = '{"rd_w7_again", 1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[7]  = '{"wr_sel_two",  1'b1, 1'b1, 8'h11, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{"rd_w0_unch",  1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{"rd_w4_unch",  1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{"rd_w2_unch",  1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[11] = '{"rd_sel_multi",1'b1, 1'b0, 8'h84, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
        vecs[12] = '{"wr_77_w0",    1'b1, 1'b1, 8'h01, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1};

        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        sel   = 8'h00;
        din   = 8'h00;
        clr   = 1'b0;
        #3;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_dout",  32'(dout),  32'h00);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].req, vecs[i].we, vecs[i].sel, vecs[i].din, 1'b0);
            check({vecs[i].name, "_ack"}, 32'(ack), 32'(vecs[i].exp_ack));
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].chk_dout) check({vecs[i].name, "_dout"}, 32'(dout), 32'(vecs[i].exp_dout));
        end
        cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        check("rd_w0_77", 32'(dout), 32'h77);

        // Fill with 0xFF, then request a read together with clr.
        fill_ff();
        cycle(1'b1, 1'b0, 8'h08, 8'h00, 1'b0);
        check("rd_ff", 32'(dout), 32'hFF);
        cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
        check("clr_req_ack", 32'(ack), 32'd0);
        check("clr_req_err", 32'(err), 32'd0);
        low_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (ready) break;
            low_cnt++;
            if (c > 0) check("clr_cycle_ack", 32'(ack), 32'd0);
            // clr re-asserted mid-clear must neither restart nor extend the walk.
            cycle(1'b1, 1'b0, 8'h01, 8'h00, (c >= 1 && c <= 3));
        end
        check("clr_ready_low_cycles", 32'(low_cnt), 32'd8);
        check("clr_exit_ack", 32'(ack), 32'd0);
        read_all_zero("after_clr");

        // Reset in the 4th CLEAR cycle must abort the walk and zero the rest.
        fill_ff();
        cycle(1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
        check("rd_ff_again", 32'(dout), 32'hFF);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        check("clr2_ready", 32'(ready), 32'd0);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        check("clr2_cycle4_ready", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midclr_rst_ready", 32'(ready), 32'd1);
        check("midclr_rst_dout",  32'(dout),  32'h00);
        req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 32'(ready), 32'd1);
        check("rel_ack",   32'(ack),   32'd0);
        check("rel_err",   32'(err),   32'd0);
        read_all_zero("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/ram_word_array.md
RAM_WORD_ARRAY -- requirements
Module: ram_word_array

Interface
REQ-001 SHALL have parameter WORDS, default 8, meaning number of storage words (one select line each).
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per word.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request; accepted when req and ready are both 1 at a rising edge.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port sel  input  WORDS  one-hot word select from the 3-to-8 address decoder.
REQ-008 SHALL have port din  input  WIDTH  write data; sampled with req.
REQ-009 SHALL have port clr  input  1  request to clear the whole array.
REQ-010 SHALL have port ready  output  1  block can accept a request this cycle.
REQ-011 SHALL have port ack  output  1  one-cycle pulse, one cycle after each accepted request.
REQ-012 SHALL have port dout  output  WIDTH  registered read data; meaningful only while ack is 1 after a read.
REQ-013 SHALL have port err  output  1  one-cycle pulse coincident with ack when the accepted sel was not exactly one-hot.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and CLEAR; ready = 1 only in IDLE.
REQ-015 Accepted write with one-hot sel SHALL update the selected word at the accepting edge.
REQ-016 Accepted read with one-hot sel SHALL load the selected word into dout at the accepting edge.
REQ-017 Latency SHALL be exactly 1 cycle: ack (and dout, err) valid in the cycle after acceptance; back-to-back requests every cycle SHALL be supported.
REQ-018 On a write ack, dout SHALL hold its previous value.
REQ-019 sel of all-zero or with more than one bit set SHALL be accepted, write no word, set dout to 0, and pulse err with ack.
REQ-020 A read accepted in the cycle directly after a write to the same word SHALL return the newly written data.
REQ-021 clr=1 in IDLE SHALL enter CLEAR at that edge; a req in the same cycle SHALL NOT be accepted.
REQ-022 In CLEAR, a counter SHALL zero word 0..WORDS-1, one per cycle, then return to IDLE: ready is low for exactly WORDS cycles.
REQ-023 The clear counter width SHALL be clog2(WORDS); the transition to IDLE SHALL occur on the cycle word WORDS-1 is cleared, with no wrap to an extra cycle.
REQ-024 clr asserted during CLEAR SHALL be ignored (no restart, no extension).
REQ-025 ack and err SHALL be 0 in every cycle not following an accepted request, including all CLEAR cycles.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, clear counter 0, all memory words 0, dout 0, ack 0, err 0; ready SHALL be 1 after release.
REQ-027 Reset asserted mid-CLEAR or mid-access SHALL abort it; no pending ack SHALL appear after release.

Structure
REQ-028 Package ram_pkg SHALL hold default WORDS/WIDTH constants and the FSM state type.
REQ-029 One sub-module onehot_check (WORDS-bit input -> valid flag, pure combinational) SHALL produce the one-hot test used for REQ-019.

Verification
REQ-030 Write 0xA5 to sel=8'b0000_0100, then read the same sel -> ack on each following cycle, read dout=0xA5, err=0.
REQ-031 Back-to-back write 0x3C to sel=8'b1000_0000 then immediate read -> dout=0x3C on the second ack, no stall cycle.
REQ-032 Read with sel=8'b0000_0000 and separately write with sel=8'b0001_0001 -> err=1 with ack, dout=0, all stored words unchanged.
REQ-033 Fill all words with 0xFF, assert clr together with req -> req not accepted, ready low for exactly 8 cycles, then all reads return 0x00.
REQ-034 Assert rst_n=0 in the 4th CLEAR cycle, then release -> ready=1, ack=0, every word reads 0x00.
